mdu_seq: RTL and testbench
==========================

# mdu_seq

Parametrised multi-cycle multiply/divide unit for the pipelined MIPS core, sitting in the E stage beside the ALU. It generalises the fixed 32-bit MDU with configurable width and per-operation latency. It adds multiply-accumulate/subtract and a defined divide-by-zero rule. The decoded `start`/`op` come from the MDU controller. `busy` feeds the hazard unit, which stalls any MD-class instruction in D while `start | busy` is high.

## Interface
- `WIDTH`, 32, operand and HI/LO width (≥ 4)
- `MUL_CYCLES`, 5, cycles from accepted start to result commit for mult/madd/msub (≥ 1)
- `DIV_CYCLES`, 10, cycles from accepted start to result commit for div/divu (≥ 1)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  launch operation `op` with `a`, `b` (one-cycle pulse)
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
- `a`, `b`  in  WIDTH each  operands (rs, rt), sampled on the accepted-start edge
- `hilo_we`  in  1  mthi/mtlo write strobe
- `hilo_sel`  in  1  1 selects HI, 0 selects LO (write target of mthi/mtlo)
- `wdata`  in  WIDTH  mthi/mtlo data
- `busy`  out  1  operation in flight
- `done`  out  1  one-cycle pulse on the commit cycle
- `div_zero`  out  1  sticky; set by a DIV/DIVU with `b`==0, cleared by the next accepted start or by reset
- `hi`, `lo`  out  WIDTH each  architectural HI/LO registers

## Operation
- States: IDLE and RUN. Down-counter `cnt` is wide enough for max(MUL_CYCLES, DIV_CYCLES).
- IDLE with `start`=1: the start is accepted.
  - Latch the operation result into pending registers `p_hi`/`p_lo`, computed from `a`, `b`, `op` and the current `hi`/`lo`.
  - Load `cnt` with the latency for `op`; go to RUN.
- RUN: `cnt` decrements each cycle. When `cnt` reaches 1, the next edge commits `hi`←`p_hi` and `lo`←`p_lo`, returns to IDLE and pulses `done`.
- MULT/MULTU: {hi,lo} = a×b, signed or unsigned, as a full 2·WIDTH product.
- MADD(U)/MSUB(U): {hi,lo} = {hi,lo} ± a×b, using the 2·WIDTH `{hi,lo}` value present at the accept edge. The result wraps modulo 2^(2·WIDTH).
- DIV/DIVU:
  - lo = quotient, hi = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Signed MIN ÷ −1 gives lo = MIN, hi = 0.
- Divide by zero (`b`==0 on DIV/DIVU): the full latency still runs and `done` still pulses, but `hi`/`lo` are left unchanged and `div_zero` is set.
- `start` while RUN is ignored; there is no queueing.
- `hilo_we` while IDLE and without `start`: the selected register ← `wdata` at the edge.
- `hilo_we` while RUN is ignored.
- `hilo_we` together with an accepted `start`: `start` wins and the write is dropped.
- Reset (at any time, including mid-RUN): aborts the operation. State → IDLE, `cnt`=0, `hi`=`lo`=0, `busy`=`done`=`div_zero`=0.

## Timing
- Outputs are registered; `busy` and `done` are derived from registered state only, never directly from `start`.
- Accept on edge k with latency N:
  - `busy`=1 during cycles k+1 … k+N.
  - `hi`/`lo` hold their new values and `done`=1 in the cycle after edge k+N.
  - `busy` falls in the same cycle that `done` rises.
- Back-to-back operation: a new `start` is accepted at edge k+N+1 (while `done` is high). The earliest new accept is the edge right after commit.
- mfhi/mflo in the `done` cycle reads the committed values; no bypass of `p_hi`/`p_lo` is provided.
- N=1: `busy` is high for exactly one cycle.

## Test plan
- Reset mid-RUN: reset for 1 cycle at k+3 of a MULT → `busy`=0, `hi`=`lo`=0 immediately (asynchronous); `done` never pulses.
- MULT signed, N=5: a=0xFFFFFFFE (−2), b=3, start at edge 0 → `busy` high cycles 1–5; in cycle 6, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA, `done`=1. MULTU with the same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV signed: a=−7, b=2 → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1), after 10 busy cycles. DIV 0x80000000 ÷ 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Divide by zero: `hi`=0x11, `lo`=0x22, DIVU b=0 → `done` pulses after 10 cycles; `hi`/`lo` unchanged; `div_zero`=1, cleared by the next MULT start.
- MADD/MSUB: mthi 0, mtlo 0xFFFFFFFF, MADDU 1×1 → `hi`=1, `lo`=0. Then MSUB 1×1 → `hi`=0, `lo`=0xFFFFFFFF.
- Collisions: `start` MULT during RUN → ignored, result from the first op only. mtlo during RUN → ignored. `hilo_we` + `start` on the same edge → the write is dropped. Repeat with WIDTH=8, MUL_CYCLES=1: 0x7F×0x7F → `hi`=0x3F, `lo`=0x01, with `busy` high for 1 cycle.

Source files
------------

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at accept, held in p_hi/p_lo, and committed after a fixed per-op latency.
module mdu_seq #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    lat;
    logic [WIDTH-1:0] p_hi, p_lo;
    logic             accept, commit;

    logic is_div, is_acc, is_sub, is_signed;

    logic [2*WIDTH-1:0] a_ext, b_ext, prod, hilo, acc_val;

    logic             a_neg, b_neg, div_by_zero;
    logic [WIDTH-1:0] a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign is_div    = (op[2:1] == 2'b01);
    assign is_acc    = op[2];
    assign is_sub    = op[2] & op[1];
    assign is_signed = ~op[0];
    assign lat       = is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);

    // Sign-extending to 2*WIDTH lets one unsigned multiplier give the signed product modulo 2^(2*WIDTH).
    always_comb begin
        a_ext   = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext   = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod    = a_ext * b_ext;
        hilo    = {hi, lo};
        acc_val = is_sub ? (hilo - prod) : (hilo + prod);
    end

    // Magnitude division: MIN / -1 falls out as quotient 2^(WIDTH-1), i.e. MIN, with remainder 0.
    always_comb begin
        a_neg       = is_signed & a[WIDTH-1];
        b_neg       = is_signed & b[WIDTH-1];
        a_mag       = a_neg ? -a : a;
        b_mag       = b_neg ? -b : b;
        div_by_zero = (b == '0);
        b_div       = div_by_zero ? WIDTH'(1) : b_mag;
        q_mag       = a_mag / b_div;
        r_mag       = a_mag % b_div;
        quo         = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem         = a_neg ? -r_mag : r_mag;
    end

    always_comb begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            if (div_by_zero) begin
                res_hi = hi;
                res_lo = lo;
            end else begin
                res_hi = rem;
                res_lo = quo;
            end
        end else if (is_acc) begin
            res_hi = acc_val[2*WIDTH-1:WIDTH];
            res_lo = acc_val[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt <= CW'(1)) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            p_hi     <= '0;
            p_lo     <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= commit;
            if (accept) begin
                p_hi     <= res_hi;
                p_lo     <= res_lo;
                cnt      <= lat;
                div_zero <= is_div & div_by_zero;
            end else if (state == RUN) begin
                cnt <= cnt - CW'(1);
            end
            if (commit) begin
                hi <= p_hi;
                lo <= p_lo;
            end else if (state == IDLE && !start && hilo_we) begin
                if (hilo_sel) hi <= wdata;
                else          lo <= wdata;
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: a 32-bit default instance and an 8-bit single-cycle-multiply instance.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset;

    logic        start, hilo_we, hilo_sel;
    logic [2:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    logic        s_start, s_hilo_we, s_hilo_sel;
    logic [2:0]  s_op;
    logic [7:0]  s_a, s_b, s_wdata;
    logic        s_busy, s_done, s_div_zero;
    logic [7:0]  s_hi, s_lo;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mdu_seq #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hilo_we(hilo_we), .hilo_sel(hilo_sel), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    mdu_seq #(.WIDTH(8), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
        .hilo_we(s_hilo_we), .hilo_sel(s_hilo_sel), .wdata(s_wdata),
        .busy(s_busy), .done(s_done), .div_zero(s_div_zero), .hi(s_hi), .lo(s_lo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_hilo(input logic sel, input logic [31:0] data);
        hilo_sel = sel;
        wdata    = data;
        hilo_we  = 1'b1;
        tick();
        hilo_we  = 1'b0;
    endtask

    // Launches one op and runs until busy drops (bounded); leaves the bench in the done cycle.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int nbusy, output logic dn);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 64; i++) begin
            if (!busy) break;
            nbusy++;
            tick();
        end
        dn = done;
    endtask

    task automatic do_op_s(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                           output int nbusy, output logic dn);
        s_op = o; s_a = x; s_b = y; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 64; i++) begin
            if (!s_busy) break;
            nbusy++;
            tick();
        end
        dn = s_done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors++; if ({busy, done, div_zero} !== 3'b000) begin miscompares++;
            $display("FAIL reset_flags: got %b want 000", {busy, done, div_zero}); end
        vectors++; if ({hi, lo} !== 64'h0) begin miscompares++;
            $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
        reset = 1'b0;
        tick();
        vectors++; if ({busy, done, hi, lo} !== 66'h0) begin miscompares++;
            $display("FAIL post_reset_idle: got %h want 0", {busy, done, hi, lo}); end
    endtask

    task automatic test_mult();
        int   nb;
        logic dn;
        do_op(3'd0, 32'hFFFFFFFE, 32'd3, nb, dn);
        vectors++; if (nb !== 5) begin miscompares++;
            $display("FAIL mult_busy_cycles: got %0d want 5", nb); end
        vectors++; if (dn !== 1'b1) begin miscompares++;
            $display("FAIL mult_done: got %b want 1", dn); end
        vectors++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFA) begin miscompares++;
            $display("FAIL mult_result: got %h want FFFFFFFFFFFFFFFA", {hi, lo}); end
        tick();
        vectors++; if (done !== 1'b0) begin miscompares++;
            $display("FAIL mult_done_pulse: got %b want 0", done); end
        do_op(3'd1, 32'hFFFFFFFE, 32'd3, nb, dn);
        vectors++; if ({hi, lo} !== 64'h00000002_FFFFFFFA) begin miscompares++;
            $display("FAIL multu_result: got %h want 00000002FFFFFFFA", {hi, lo}); end
    endtask

    task automatic test_div();
        int   nb;
        logic dn;
        do_op(3'd2, 32'hFFFFFFF9, 32'd2, nb, dn);
        vectors++; if (nb !== 10) begin miscompares++;
            $display("FAIL div_busy_cycles: got %0d want 10", nb); end
        vectors++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin miscompares++;
            $display("FAIL div_neg7_2: got %h want FFFFFFFFFFFFFFFD", {hi, lo}); end
        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, nb, dn);
        vectors++; if ({hi, lo} !== 64'h00000000_80000000) begin miscompares++;
            $display("FAIL div_min_m1: got %h want 0000000080000000", {hi, lo}); end
        do_op(3'd2, 32'd7, 32'hFFFFFFFE, nb, dn);
        vectors++; if ({hi, lo} !== 64'h00000001_FFFFFFFD) begin miscompares++;
            $display("FAIL div_7_neg2: got %h want 00000001FFFFFFFD", {hi, lo}); end
        do_op(3'd3, 32'd100, 32'd7, nb, dn);
        vectors++; if ({hi, lo} !== 64'h00000002_0000000E) begin miscompares++;
            $display("FAIL divu_100_7: got %h want 000000020000000E", {hi, lo}); end
    endtask

    task automatic test_div_zero();
        int   nb;
        logic dn;
        write_hilo(1'b1, 32'h11);
        write_hilo(1'b0, 32'h22);
        vectors++; if ({hi, lo} !== 64'h00000011_00000022) begin miscompares++;
            $display("FAIL mthi_mtlo: got %h want 0000001100000022", {hi, lo}); end
        do_op(3'd3, 32'd55, 32'd0, nb, dn);
        vectors++; if (nb !== 10 || dn !== 1'b1) begin miscompares++;
            $display("FAIL divz_timing: got busy=%0d done=%b want 10/1", nb, dn); end
        vectors++; if ({hi, lo} !== 64'h00000011_00000022) begin miscompares++;
            $display("FAIL divz_hilo_kept: got %h want 0000001100000022", {hi, lo}); end
        vectors++; if (div_zero !== 1'b1) begin miscompares++;
            $display("FAIL divz_flag_set: got %b want 1", div_zero); end
        do_op(3'd0, 32'd2, 32'd3, nb, dn);
        vectors++; if (div_zero !== 1'b0) begin miscompares++;
            $display("FAIL divz_flag_clear: got %b want 0", div_zero); end
        vectors++; if ({hi, lo} !== 64'h00000000_00000006) begin miscompares++;
            $display("FAIL mult_after_divz: got %h want 0000000000000006", {hi, lo}); end
    endtask

    task automatic test_madd();
        int   nb;
        logic dn;
        write_hilo(1'b1, 32'h0);
        write_hilo(1'b0, 32'hFFFFFFFF);
        do_op(3'd5, 32'd1, 32'd1, nb, dn);
        vectors++; if ({hi, lo} !== 64'h00000001_00000000) begin miscompares++;
            $display("FAIL maddu_carry: got %h want 0000000100000000", {hi, lo}); end
        do_op(3'd6, 32'd1, 32'd1, nb, dn);
        vectors++; if ({hi, lo} !== 64'h00000000_FFFFFFFF) begin miscompares++;
            $display("FAIL msub_borrow: got %h want 00000000FFFFFFFF", {hi, lo}); end
        do_op(3'd4, 32'hFFFFFFFF, 32'd1, nb, dn);
        vectors++; if ({hi, lo} !== 64'h00000000_FFFFFFFE) begin miscompares++;
            $display("FAIL madd_signed: got %h want 00000000FFFFFFFE", {hi, lo}); end
    endtask

    task automatic test_collisions();
        int nb;
        op = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        nb = 0;
        for (int i = 0; i < 64; i++) begin
            if (!busy) break;
            nb++;
            if (i == 1) begin
                start = 1'b1; a = 32'd5; b = 32'd5;
                hilo_we = 1'b1; hilo_sel = 1'b0; wdata = 32'hDEAD;
            end else begin
                start = 1'b0; hilo_we = 1'b0;
            end
            tick();
        end
        start = 1'b0; hilo_we = 1'b0;
        vectors++; if (nb !== 5 || done !== 1'b1) begin miscompares++;
            $display("FAIL run_collide_timing: got busy=%0d done=%b want 5/1", nb, done); end
        vectors++; if ({hi, lo} !== 64'h00000000_0000000C) begin miscompares++;
            $display("FAIL run_collide_result: got %h want 000000000000000C", {hi, lo}); end
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++;
            $display("FAIL run_start_queued: got busy=%b want 0", busy); end
        // Write to HI on the accept edge must be dropped; MADDU then uses HI=0.
        op = 3'd5; a = 32'd1; b = 32'd1; start = 1'b1;
        hilo_we = 1'b1; hilo_sel = 1'b1; wdata = 32'h55;
        tick();
        start = 1'b0; hilo_we = 1'b0;
        vectors++; if (hi !== 32'h0) begin miscompares++;
            $display("FAIL we_start_drop: got hi=%h want 00000000", hi); end
        for (int i = 0; i < 64; i++) begin
            if (!busy) break;
            tick();
        end
        vectors++; if ({hi, lo} !== 64'h00000000_0000000D) begin miscompares++;
            $display("FAIL we_start_result: got %h want 000000000000000D", {hi, lo}); end
    endtask

    task automatic test_back_to_back();
        int   nb;
        logic dn;
        do_op(3'd0, 32'd2, 32'd3, nb, dn);
        op = 3'd1; a = 32'd4; b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++;
            $display("FAIL b2b_accept: got busy=%b done=%b want 1/0", busy, done); end
        vectors++; if (lo !== 32'd6) begin miscompares++;
            $display("FAIL b2b_first: got lo=%h want 00000006", lo); end
        nb = 0;
        for (int i = 0; i < 64; i++) begin
            if (!busy) break;
            nb++;
            tick();
        end
        vectors++; if (nb !== 5 || lo !== 32'd20 || hi !== 32'd0) begin miscompares++;
            $display("FAIL b2b_second: got busy=%0d hi=%h lo=%h want 5/0/14", nb, hi, lo); end
    endtask

    task automatic test_reset_mid_run();
        logic seen_done;
        write_hilo(1'b1, 32'h1234);
        op = 3'd0; a = 32'd2; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        vectors++; if ({busy, done} !== 2'b00) begin miscompares++;
            $display("FAIL midrun_reset_flags: got %b want 00", {busy, done}); end
        vectors++; if ({hi, lo} !== 64'h0) begin miscompares++;
            $display("FAIL midrun_reset_hilo: got %h want 0", {hi, lo}); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) seen_done = 1'b1;
            tick();
        end
        vectors++; if (seen_done !== 1'b0) begin miscompares++;
            $display("FAIL midrun_no_done: got activity=%b want 0", seen_done); end
    endtask

    task automatic test_small();
        int   nb;
        logic dn;
        do_op_s(3'd0, 8'h7F, 8'h7F, nb, dn);
        vectors++; if (nb !== 1 || dn !== 1'b1) begin miscompares++;
            $display("FAIL w8_mult_timing: got busy=%0d done=%b want 1/1", nb, dn); end
        vectors++; if ({s_hi, s_lo} !== 16'h3F01) begin miscompares++;
            $display("FAIL w8_mult_7f: got %h want 3F01", {s_hi, s_lo}); end
        do_op_s(3'd1, 8'hFF, 8'hFF, nb, dn);
        vectors++; if ({s_hi, s_lo} !== 16'hFE01) begin miscompares++;
            $display("FAIL w8_multu_ff: got %h want FE01", {s_hi, s_lo}); end
        do_op_s(3'd0, 8'hFF, 8'hFF, nb, dn);
        vectors++; if ({s_hi, s_lo} !== 16'h0001) begin miscompares++;
            $display("FAIL w8_mult_m1: got %h want 0001", {s_hi, s_lo}); end
        do_op_s(3'd2, 8'h80, 8'hFF, nb, dn);
        vectors++; if (nb !== 3 || {s_hi, s_lo} !== 16'h0080) begin miscompares++;
            $display("FAIL w8_div_min: got busy=%0d %h want 3/0080", nb, {s_hi, s_lo}); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; op = 3'd0; a = '0; b = '0;
        hilo_we = 1'b0; hilo_sel = 1'b0; wdata = '0;
        s_start = 1'b0; s_op = 3'd0; s_a = '0; s_b = '0;
        s_hilo_we = 1'b0; s_hilo_sel = 1'b0; s_wdata = '0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_madd();
        test_collisions();
        test_back_to_back();
        test_small();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
